// File: rtl/lock_controller_pkg.sv
// Shared types and BCD helpers for the combination-lock controller.
package lock_pkg;

    localparam int         NUM_DIGITS_DEFAULT = 6;
    localparam logic [3:0] BCD_MAX            = 4'd9;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_e;

    // Out-of-range BCD values fold back into 0..9 instead of propagating.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0 || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Control/status bundle between the number-input stage, the lock controller and the display.
interface lock_controller_if #(parameter int NUM_DIGITS = lock_pkg::NUM_DIGITS_DEFAULT);
    logic                    tick;
    logic [2:0]              cur_pos;
    logic                    digit_up;
    logic                    digit_dn;
    logic                    save;
    logic [4*NUM_DIGITS-1:0] entry_digits;
    logic                    unlocked;
    logic                    fail_led;
    logic                    locked_out;
    logic [1:0]              tries_left;
    logic [2:0]              state_o;

    modport master (
        output tick, cur_pos, digit_up, digit_dn, save,
        input  entry_digits, unlocked, fail_led, locked_out, tries_left, state_o
    );

    modport slave (
        input  tick, cur_pos, digit_up, digit_dn, save,
        output entry_digits, unlocked, fail_led, locked_out, tries_left, state_o
    );
endinterface

// File: rtl/lock_tick_timer.sv
// Slow-tick counter shared by the FAIL, LOCKOUT and OPEN windows; saturates at limit.
module lock_tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         hold,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cnt <= '0;
        else if (clr)                             cnt <= '0;
        else if (tick && !hold && (cnt != limit)) cnt <= cnt + 1'b1;
    end

    assign done = (cnt == limit);
endmodule

// File: rtl/lock_controller.sv
// Combination-lock sequencer: BCD entry editing, code compare, open/fail/lockout timing.
// Define LOCK_CODE_PROGRAM_EN to let a save while OPEN reprogram the stored code.
module lock_controller
    import lock_pkg::*;
#(
    parameter int                      NUM_DIGITS    = NUM_DIGITS_DEFAULT,
    parameter int                      MAX_TRIES     = 3,
    parameter int                      FAIL_TICKS    = 2,
    parameter int                      LOCKOUT_TICKS = 10,
    parameter int                      OPEN_TICKS    = 5,
    parameter logic [4*NUM_DIGITS-1:0] RESET_CODE    = '0
) (
    input logic              clk,
    input logic              rst_n,
    lock_controller_if.slave lk
);
    localparam int TMAX = (FAIL_TICKS > LOCKOUT_TICKS)
                        ? ((FAIL_TICKS > OPEN_TICKS) ? FAIL_TICKS : OPEN_TICKS)
                        : ((LOCKOUT_TICKS > OPEN_TICKS) ? LOCKOUT_TICKS : OPEN_TICKS);
    localparam int         TW         = $clog2(TMAX + 1);
    localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

    lock_state_e                 state, state_nx;
    logic [NUM_DIGITS-1:0][3:0]  entry, entry_ed, code;
    logic [1:0]                  tries;
    logic                        entered, edit, match;
    logic                        t_clr, t_done;
    logic [TW-1:0]               t_limit;
    logic                        unlocked_nx, fail_nx, lockout_nx;

    // Edit is folded in ahead of the register so a same-cycle save sees the new digit.
    always_comb begin
        entry_ed = entry;
        edit     = (state == ENTRY || state == OPEN) && (lk.digit_up ^ lk.digit_dn)
                   && (int'(lk.cur_pos) < NUM_DIGITS);
        if (edit)
            entry_ed[lk.cur_pos] = lk.digit_up ? bcd_inc(entry[lk.cur_pos])
                                               : bcd_dec(entry[lk.cur_pos]);
    end

    assign match = (entry == code);

    always_comb begin
        state_nx = state;
        case (state)
            ENTRY:   if (lk.save) state_nx = CHECK;
            CHECK:   if (match)             state_nx = OPEN;
                     else if (tries <= 2'd1) state_nx = LOCKOUT;
                     else                    state_nx = FAIL;
            OPEN:    if (lk.save || (!edit && t_done)) state_nx = ENTRY;
            FAIL:    if (t_done) state_nx = ENTRY;
            LOCKOUT: if (t_done) state_nx = ENTRY;
            default: state_nx = ENTRY;
        endcase
    end

    always_comb begin
        unlocked_nx = (state_nx == OPEN);
        fail_nx     = (state_nx == FAIL);
        lockout_nx  = (state_nx == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ENTRY;
            entered       <= 1'b0;
            lk.unlocked   <= 1'b0;
            lk.fail_led   <= 1'b0;
            lk.locked_out <= 1'b0;
        end else begin
            state         <= state_nx;
            entered       <= (state_nx != state);
            lk.unlocked   <= unlocked_nx;
            lk.fail_led   <= fail_nx;
            lk.locked_out <= lockout_nx;
        end
    end

    // Timer restarts on every state change and on any edit while open; the tick in
    // the first cycle of a state is swallowed via hold.
    assign t_clr = (state_nx != state) || (state == OPEN && edit);

    always_comb begin
        case (state)
            FAIL:    t_limit = TW'(FAIL_TICKS);
            LOCKOUT: t_limit = TW'(LOCKOUT_TICKS);
            default: t_limit = TW'(OPEN_TICKS);
        endcase
    end

    lock_tick_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (t_clr),
        .hold  (entered),
        .tick  (lk.tick),
        .limit (t_limit),
        .done  (t_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            code  <= RESET_CODE;
            tries <= TRIES_INIT;
        end else begin
            entry <= entry_ed;
            case (state)
                CHECK: begin
                    if (match) begin
                        entry <= '0;
                        tries <= TRIES_INIT;
                    end else begin
                        tries <= tries - 2'd1;
                    end
                end
                OPEN: begin
                    if (lk.save) begin
                        entry <= '0;
`ifdef LOCK_CODE_PROGRAM_EN
                        code  <= entry_ed;
`endif
                    end else if (state_nx == ENTRY) begin
                        entry <= '0;
                    end
                end
                FAIL:    if (t_done) entry <= '0;
                LOCKOUT: if (t_done) begin
                    entry <= '0;
                    tries <= TRIES_INIT;
                end
                default: ;
            endcase
        end
    end

    assign lk.entry_digits = entry;
    assign lk.tries_left   = tries;
    assign lk.state_o      = state;
endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus pushes model predictions, monitor compares.
module tb_lock_controller;
    localparam int ND = 6, MT = 3, FT = 2, LT = 10, OT = 5;
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4;

    typedef int dig_t[ND];
    typedef struct packed {
        logic [4*ND-1:0] ent;
        logic            unl;
        logic            fl;
        logic            lo;
        logic [1:0]      tries;
        logic [2:0]      st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_controller_if #(.NUM_DIGITS(ND)) lk();

    lock_controller #(
        .NUM_DIGITS(ND), .MAX_TRIES(MT), .FAIL_TICKS(FT),
        .LOCKOUT_TICKS(LT), .OPEN_TICKS(OT), .RESET_CODE(24'h000000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lk    (lk)
    );

    exp_t q[$];
    int   vectors = 0, miscompares = 0;

    // Reference model: the lock as described by its rules, one step per clock.
    int   m_mode, m_cnt, m_tries;
    bit   m_fresh;
    dig_t m_dig, m_code;
    dig_t zero_d  = '{0, 0, 0, 0, 0, 0};
    dig_t wrong_d = '{6, 5, 4, 3, 2, 1};
    dig_t prog_d  = '{2, 4, 0, 2, 4, 0};

    function automatic bit same(input dig_t a, input dig_t b);
        for (int i = 0; i < ND; i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < ND; i++) e.ent[4*i +: 4] = 4'(m_dig[i]);
        e.unl   = (m_mode == M_OPEN);
        e.fl    = (m_mode == M_FAIL);
        e.lo    = (m_mode == M_LOCK);
        e.tries = 2'(m_tries);
        e.st    = 3'(m_mode);
        return e;
    endfunction

    task automatic m_reset();
        m_mode = M_ENTRY; m_cnt = 0; m_fresh = 1'b0; m_tries = MT;
        m_dig = zero_d; m_code = zero_d;
    endtask

    task automatic m_step(input bit up, input bit dn, input bit sv, input bit tk, input int pos);
        dig_t nd;
        bit   ed;
        int   nxt;
        nd  = m_dig;
        nxt = m_mode;
        ed  = (m_mode == M_ENTRY || m_mode == M_OPEN) && (up != dn) && pos < ND;
        if (ed) nd[pos] = up ? (m_dig[pos] + 1) % 10 : (m_dig[pos] + 9) % 10;
        case (m_mode)
            M_ENTRY: if (sv) nxt = M_CHECK;
            M_CHECK: begin
                if (same(m_dig, m_code)) begin
                    nxt = M_OPEN; m_tries = MT; nd = zero_d;
                end else begin
                    m_tries = m_tries - 1;
                    nxt = (m_tries == 0) ? M_LOCK : M_FAIL;
                end
            end
            M_OPEN: begin
                if (sv) begin
`ifdef LOCK_CODE_PROGRAM_EN
                    m_code = nd;
`endif
                    nd = zero_d; nxt = M_ENTRY;
                end else if (ed) m_cnt = 0;
                else if (m_cnt == OT) begin nxt = M_ENTRY; nd = zero_d; end
                else if (tk && !m_fresh) m_cnt++;
            end
            M_FAIL: begin
                if (m_cnt == FT) begin nxt = M_ENTRY; nd = zero_d; end
                else if (tk && !m_fresh) m_cnt++;
            end
            default: begin
                if (m_cnt == LT) begin nxt = M_ENTRY; nd = zero_d; m_tries = MT; end
                else if (tk && !m_fresh) m_cnt++;
            end
        endcase
        m_fresh = (nxt != m_mode);
        if (m_fresh) m_cnt = 0;
        m_dig  = nd;
        m_mode = nxt;
    endtask

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = {lk.entry_digits, lk.unlocked, lk.fail_led, lk.locked_out, lk.tries_left, lk.state_o};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got ent=%h unl=%b fl=%b lo=%b tries=%0d st=%0d, want ent=%h unl=%b fl=%b lo=%b tries=%0d st=%0d",
                     name, $time, a.ent, a.unl, a.fl, a.lo, a.tries, a.st,
                     e.ent, e.unl, e.fl, e.lo, e.tries, e.st);
        end
    endtask

    // Monitor: one prediction per active clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("scoreboard", e);
            end
        end
    end

    task automatic cyc(input bit up, input bit dn, input bit sv, input bit tk, input int pos);
        @(negedge clk);
        lk.digit_up = up; lk.digit_dn = dn; lk.save = sv; lk.tick = tk;
        lk.cur_pos  = 3'(pos);
        m_step(up, dn, sv, tk, pos);
        q.push_back(model_out());
    endtask

    task automatic set_entry(input dig_t t);
        for (int i = 0; i < ND; i++)
            for (int k = 0; k < 10 && m_dig[i] != t[i]; k++) cyc(1, 0, 0, 0, i);
    endtask

    task automatic wait_entry(input int maxc);
        for (int i = 0; i < maxc && m_mode != M_ENTRY; i++) cyc(0, 0, 0, (i % 2) == 1, 0);
    endtask

    task automatic attempt(input dig_t t);
        set_entry(t);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        lk.tick = 0; lk.cur_pos = 0; lk.digit_up = 0; lk.digit_dn = 0; lk.save = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 compare("reset_values", model_out());
        @(negedge clk) rst_n = 1'b1;

        // digit wrap up 0..9..0 then down 0->9 and back
        repeat (10) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // correct code, then idle relock
        attempt(zero_d);
        wait_entry(60);

        // three wrong attempts into lockout; edits during lockout do nothing
        for (int k = 0; k < 3; k++) begin
            attempt(wrong_d);
            if (k < 2) wait_entry(40);
        end
        repeat (3) cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 3);
        wait_entry(60);

        // simultaneous up/down and out-of-range cursor
        cyc(1, 0, 0, 0, 2);
        cyc(1, 1, 0, 0, 2);
        cyc(1, 0, 0, 0, 6);
        cyc(0, 1, 0, 0, 7);

        // save while open: reprograms only when the feature is built in
        attempt(zero_d);
        set_entry(prog_d);
        cyc(0, 0, 1, 0, 0);
        attempt(zero_d);
        if (m_mode == M_OPEN) cyc(0, 0, 1, 0, 0);
        wait_entry(40);
        attempt(prog_d);
        wait_entry(60);

        // randomized traffic, with occasional correct entries to reach OPEN
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (m_mode == M_ENTRY && $urandom_range(0, 24) == 0) begin
                attempt(m_code);
            end else begin
                cyc(r < 25, r >= 20 && r < 45, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
            end
        end
        wait_entry(60);

        // asynchronous reset in the middle of a lockout count
        for (int k = 0; k < 3; k++) begin
            attempt(wrong_d);
            if (k < 2) wait_entry(40);
        end
        repeat (4) cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 m_reset();
        compare("reset_in_lockout", model_out());
        @(negedge clk) rst_n = 1'b1;
        attempt(zero_d);
        cyc(0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d predictions left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
